ppu_oam_writer: RTL

Write side of the PPU sprite RAM (OAM). It takes CPU writes to OAMADDR ($2003) and OAMDATA ($2004), and runs the 256-byte OAM DMA triggered by a write to $4014. It produces the single registered write port into the 256x8 sprite RAM. It also exports the current OAM address, which the sprite load FSM uses as its scan start address.

---
 rtl/ppu_oam_writer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/ppu_oam_writer.sv
// PPU sprite RAM write side.
// Handles CPU OAMADDR/OAMDATA writes and the 256-byte OAM DMA.
module ppu_oam_writer (
  input  logic        clk,
  input  logic        rst,
  input  logic        oamaddr_wr,
  input  logic        oamdata_wr,
  input  logic        dma_wr,
  input  logic [7:0]  cpu_wdata,
  input  logic        in_render,
  output logic [7:0]  cpu_sprite_addr,
  output logic        cpu_halt,
  output logic        dma_busy,
  output logic [15:0] dma_bus_addr,
  output logic        dma_bus_rd,
  input  logic [7:0]  dma_bus_data,
  output logic        spram_wr_en,
  output logic [7:0]  spram_wr_addr,
  output logic [7:0]  spram_wr_data
);

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } state_t;

  state_t      state_q, state_d;
  logic        parity_q;
  logic [7:0]  page_q, page_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [7:0]  addr_q, addr_d;
  logic        halt_q, halt_d;
  logic        rd_q, rd_d;
  logic [15:0] bus_addr_q, bus_addr_d;
  logic        wr_en_q, wr_en_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      parity_q   <= 1'b0;
      page_q     <= 8'h00;
      cnt_q      <= 9'h000;
      addr_q     <= 8'h00;
      halt_q     <= 1'b0;
      rd_q       <= 1'b0;
      bus_addr_q <= 16'h0000;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 8'h00;
      wr_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      parity_q   <= ~parity_q;
      page_q     <= page_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      halt_q     <= halt_d;
      rd_q       <= rd_d;
      bus_addr_q <= bus_addr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    page_d     = page_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_d       = 1'b0;
    bus_addr_d = bus_addr_q;
    unique case (state_q)
      IDLE: begin
        if (oamaddr_wr) begin
          addr_d = cpu_wdata;
        end else if (oamdata_wr && !in_render) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = cpu_wdata;
          addr_d    = addr_q + 8'd1;
        end
        if (dma_wr) begin
          page_d  = cpu_wdata;
          cnt_d   = 9'h000;
          state_d = HALT;
        end
      end
      HALT:  state_d = parity_q ? ALIGN : READ;
      ALIGN: state_d = READ;
      READ:  state_d = WRITE;
      WRITE: begin
        cnt_d   = cnt_q + 9'd1;
        state_d = cnt_d[8] ? IDLE : READ;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered against the state being entered
    halt_d = (state_d != IDLE);
    if (state_d == READ) begin
      rd_d       = 1'b1;
      bus_addr_d = {page_d, cnt_d[7:0]};
    end
    if (state_d == WRITE) begin
      wr_en_d   = 1'b1;
      wr_addr_d = addr_q + cnt_d[7:0];
    end
  end

  assign cpu_sprite_addr = addr_q;
  assign cpu_halt        = halt_q;
  assign dma_busy        = halt_q;
  assign dma_bus_rd      = rd_q;
  assign dma_bus_addr    = bus_addr_q;
  assign spram_wr_en     = wr_en_q;
  assign spram_wr_addr   = wr_addr_q;
  // Bus data only arrives in the WRITE cycle, so it bypasses the data register
  assign spram_wr_data   = (state_q == WRITE) ? dma_bus_data : wr_data_q;

endmodule
